// File: rtl/opl_wq_pkg.sv
// Shared types and constants for the OPL register-write queue.
// Queue entries carry {bank, register number, data}; the bank field is
// sized for the widest supported bank select (ADDR_W up to 9).
package opl_wq_pkg;

  localparam int OPL_WQ_BANK_MAX_W = 8;

  // addr[0] selects between the register-number latch and the data port.
  localparam logic OPL_WQ_LATCH = 1'b0;
  localparam logic OPL_WQ_DATA  = 1'b1;

  typedef struct packed {
    logic [OPL_WQ_BANK_MAX_W-1:0] bank;
    logic [7:0]                   reg_num;
    logic [7:0]                   data;
  } opl_wq_entry_t;

  // Bank select width: the address bits above the latch/data select, at least one.
  function automatic int opl_wq_bank_w(input int addr_w);
    return (addr_w > 2) ? (addr_w - 1) : 1;
  endfunction

endpackage

// File: rtl/opl_wq_ram.sv
// Simple dual-port synchronous RAM with a registered read port.
// The read register is cleared on reset so the queue head reads as zero.
module opl_wq_ram #(
  parameter int W     = 24,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Write port into the storage array; the array contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port returning the word addressed in the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= {W{1'b0}};
    end else begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/opl_wr_queue.sv
// OPL register-write queue: pairs per-bank address-latch writes with data
// writes and queues complete {bank, reg, data} entries for the sequencer.
// Show-ahead head outputs, sticky overflow flag, and an optional drift-free
// fractional sample strobe compiled in when OPL_WQ_STROBE_EN is defined
// (otherwise stb is tied low and the sample rate comes from elsewhere).
module opl_wr_queue
  import opl_wq_pkg::*;
#(
  parameter  int ADDR_W = 2,
  parameter  int DEPTH  = 1024,
  parameter  int OPLCLK = 50000000,
  parameter  int SRATE  = 44100,
  localparam int BANK_W = opl_wq_bank_w(ADDR_W),
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        din,
  output logic              q_valid,
  output logic [BANK_W-1:0] q_bank,
  output logic [7:0]        q_reg,
  output logic [7:0]        q_data,
  input  logic              q_pop,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              stb
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int NBANK = 1 << BANK_W;
  localparam int ENT_W = $bits(opl_wq_entry_t);

  // Reject configurations the queue and strobe logic cannot support.
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) || (SRATE >= OPLCLK) ||
      (BANK_W > OPL_WQ_BANK_MAX_W)) begin : g_bad_params
    $error("opl_wr_queue: unsupported parameter combination");
  end

  logic [7:0]       lat_r [NBANK];
  logic [NBANK-1:0] lat_v_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [BANK_W-1:0] bank_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             commit_s;
  logic             drop_s;
  opl_wq_entry_t    wr_ent_s;
  opl_wq_entry_t    rd_ent_s;
  logic             unused_bank_s;

  // Decode the port write into a push request and qualify the head pop.
  always_comb begin
    bank_s           = BANK_W'(addr >> 1'b1);
    push_s           = wr & (addr[0] == OPL_WQ_DATA) & lat_v_r[bank_s];
    pop_s            = q_pop & q_valid;
    full_s           = (level == LVL_W'(DEPTH));
    commit_s         = push_s & (~full_s | pop_s);
    drop_s           = push_s & full_s & ~pop_s;
    rd_ptr_nxt_s     = rd_ptr_r + PTR_W'(pop_s);
    wr_ent_s.bank    = OPL_WQ_BANK_MAX_W'(bank_s);
    wr_ent_s.reg_num = lat_r[bank_s];
    wr_ent_s.data    = din;
  end

  // Per-bank register-number latches; kept after use so data writes can repeat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_v_r <= {NBANK{1'b0}};
      for (int i = 0; i < NBANK; i++) begin
        lat_r[i] <= 8'h00;
      end
    end else if (wr && (addr[0] == OPL_WQ_LATCH)) begin
      lat_r[bank_s]   <= din;
      lat_v_r[bank_s] <= 1'b1;
    end
  end

  // Pointers, occupancy, sticky overflow (set beats clear) and head-valid flag.
  // The head becomes valid one edge after its entry is written, because the
  // RAM read of the next-pointer address returns the pre-write contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level    <= {LVL_W{1'b0}};
      overflow <= 1'b0;
      q_valid  <= 1'b0;
    end else begin
      if (commit_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      level    <= level + LVL_W'(commit_s) - LVL_W'(pop_s);
      if (drop_s) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
      q_valid <= (level > LVL_W'(pop_s));
    end
  end

  opl_wq_ram #(
    .W     (ENT_W),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset_n),
    .we    (commit_s),
    .waddr (wr_ptr_r),
    .wdata (wr_ent_s),
    .raddr (rd_ptr_nxt_s),
    .rdata (rd_ent_s)
  );

  assign q_bank        = BANK_W'(rd_ent_s.bank);
  assign q_reg         = rd_ent_s.reg_num;
  assign q_data        = rd_ent_s.data;
  assign unused_bank_s = ^rd_ent_s.bank;

`ifdef OPL_WQ_STROBE_EN
  localparam int ACC_W = $clog2(OPLCLK) + 1;

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_sum_s;

  // Accumulator value after adding one cycle's worth of sample rate.
  always_comb acc_sum_s = acc_r + ACC_W'(SRATE);

  // Fractional accumulator: wrap by OPLCLK and pulse the strobe on each wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r <= {ACC_W{1'b0}};
      stb   <= 1'b0;
    end else if (acc_sum_s >= ACC_W'(OPLCLK)) begin
      acc_r <= acc_sum_s - ACC_W'(OPLCLK);
      stb   <= 1'b1;
    end else begin
      acc_r <= acc_sum_s;
      stb   <= 1'b0;
    end
  end
`else
  assign stb = 1'b0;
`endif

endmodule

// File: tb/tb_opl_wr_queue.sv
// Self-checking bench for opl_wr_queue (ADDR_W=3, DEPTH=4, OPLCLK=10, SRATE=3).
// A transaction-level reference model advances on each clock edge; a monitor
// on the falling edge compares the DUT against it and the scoreboard queue.
module tb_opl_wr_queue;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;
  localparam int OPLCLK = 10;
  localparam int SRATE  = 3;
  localparam int BANK_W = 2;
  localparam int LVL_W  = 3;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b0;
  logic              wr      = 1'b0;
  logic [ADDR_W-1:0] addr    = '0;
  logic [7:0]        din     = 8'h00;
  logic              q_pop   = 1'b0;
  logic              ovf_clr = 1'b0;
  logic              q_valid;
  logic [BANK_W-1:0] q_bank;
  logic [7:0]        q_reg;
  logic [7:0]        q_data;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic              stb;

  int n_tests = 0;
  int n_fail  = 0;

  opl_wr_queue #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .OPLCLK (OPLCLK),
    .SRATE  (SRATE)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr       (wr),
    .addr     (addr),
    .din      (din),
    .q_valid  (q_valid),
    .q_bank   (q_bank),
    .q_reg    (q_reg),
    .q_data   (q_data),
    .q_pop    (q_pop),
    .level    (level),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .stb      (stb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int     bank;
    int     rg;
    int     data;
    longint stamp;   // clock edge at which the entry entered the queue
  } ent_t;

  ent_t   sb[$];
  int     m_lat [4];
  bit     m_latv[4];
  bit     m_ovf;
  bit     m_vis;
  longint m_edge;
  bit     m_pop;
  bit     m_push;
  bit     m_drop;
  int     m_b;

  // Expected strobe after edge k: the count floor(k*SRATE/OPLCLK) just stepped.
  function automatic bit exp_stb(input longint k);
`ifdef OPL_WQ_STROBE_EN
    if (k < 1) return 1'b0;
    return ((k * SRATE) / OPLCLK) != (((k - 1) * SRATE) / OPLCLK);
`else
    return 1'b0;
`endif
  endfunction

  // Model update: applies one edge's worth of the queue rules to the inputs.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb.delete();
      for (int i = 0; i < 4; i++) m_latv[i] = 1'b0;
      m_ovf  = 1'b0;
      m_vis  = 1'b0;
      m_edge = 0;
    end else begin
      m_edge++;
      m_b    = int'(addr) >> 1;
      m_pop  = q_pop && m_vis;
      m_push = wr && addr[0] && m_latv[m_b];
      m_drop = m_push && (sb.size() == DEPTH) && !m_pop;
      if (m_pop) void'(sb.pop_front());
      if (m_push && !m_drop)
        sb.push_back('{bank: m_b, rg: m_lat[m_b], data: int'(din), stamp: m_edge});
      if (m_drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (wr && !addr[0]) begin
        m_lat[m_b]  = int'(din);
        m_latv[m_b] = 1'b1;
      end
      m_vis = (sb.size() > 0) && (sb[0].stamp < m_edge);
    end
  end

  // Monitor: compares DUT state and the show-ahead head against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      check("q_valid", q_valid, m_vis);
      check("level", level, sb.size());
      check("overflow", overflow, m_ovf);
      check("stb", stb, exp_stb(m_edge));
      if (q_valid && sb.size() > 0) begin
        check("head_bank", q_bank, sb[0].bank);
        check("head_reg", q_reg, sb[0].rg);
        check("head_data", q_data, sb[0].data);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic port_wr(input int a, input int d);
    wr = 1'b1; addr = ADDR_W'(a); din = 8'(d);
    tick();
    wr = 1'b0;
  endtask

  int cnt;
  logic [7:0] drain_exp [4];

  initial begin
    repeat (3) tick();
    check("rst_q_valid", q_valid, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_stb", stb, 0);
    check("rst_q_bank", q_bank, 0);
    check("rst_q_reg", q_reg, 0);
    check("rst_q_data", q_data, 0);
    reset_n = 1'b1;

    // Data write to bank 0 with no latch: dropped, no overflow.
    port_wr(1, 8'h55);
    repeat (2) tick();
    check("nolatch_level", level, 0);
    check("nolatch_ovf", overflow, 0);

    // Pairing: one latch, two data writes reuse it.
    port_wr(0, 8'h20); port_wr(1, 8'h01); port_wr(1, 8'h21);
    repeat (2) tick();
    check("pair_level", level, 2);
    check("pair_head_reg", q_reg, 8'h20);
    check("pair_head_data", q_data, 8'h01);
    q_pop = 1'b1; tick();
    check("pair_second_data", q_data, 8'h21);
    tick(); q_pop = 1'b0;
    check("pair_empty_valid", q_valid, 0);
    check("pair_empty_level", level, 0);

    // Bank 1 via address 2/3.
    port_wr(2, 8'hB0); port_wr(3, 8'h31);
    tick();
    check("bank_q_bank", q_bank, 1);
    check("bank_q_reg", q_reg, 8'hB0);
    check("bank_q_data", q_data, 8'h31);
    q_pop = 1'b1; tick(); q_pop = 1'b0;

    // Latency: level rises at the edge capturing the write, head one edge later.
    port_wr(1, 8'h77);
    check("lat_level_first", level, 1);
    check("lat_valid_first", q_valid, 0);
    tick();
    check("lat_valid_second", q_valid, 1);
    check("lat_data", q_data, 8'h77);
    q_pop = 1'b1; tick(); q_pop = 1'b0;

    // Full: five data writes into a 4-deep queue.
    for (int i = 0; i < 5; i++) port_wr(1, 8'h40 + i);
    check("full_level", level, 4);
    check("full_ovf", overflow, 1);
    // Pop and push together on full: level holds, no new overflow.
    wr = 1'b1; addr = 3'd1; din = 8'h50; q_pop = 1'b1;
    tick();
    wr = 1'b0; q_pop = 1'b0;
    check("fullpp_level", level, 4);
    check("fullpp_ovf", overflow, 1);
    // Clear together with a fresh overflow: set wins.
    wr = 1'b1; addr = 3'd1; din = 8'h60; ovf_clr = 1'b1;
    tick();
    wr = 1'b0;
    check("setwins_ovf", overflow, 1);
    tick(); ovf_clr = 1'b0;
    check("clr_ovf", overflow, 0);
    // Back-to-back pops drain four entries in four cycles, in order.
    drain_exp[0] = 8'h41; drain_exp[1] = 8'h42; drain_exp[2] = 8'h43; drain_exp[3] = 8'h50;
    q_pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_data", q_data, drain_exp[i]);
      tick();
    end
    q_pop = 1'b0;
    check("drain_valid", q_valid, 0);
    check("drain_level", level, 0);

    // Strobe count over one full OPLCLK window.
    cnt = 0;
    repeat (OPLCLK) begin
      @(negedge clk);
      cnt += int'(stb);
    end
    tick();
`ifdef OPL_WQ_STROBE_EN
    check("stb_per_window", cnt, SRATE);
`else
    check("stb_never", cnt, 0);
`endif

    // Reset with entries queued discards everything immediately.
    port_wr(1, 8'h81); port_wr(1, 8'h82); port_wr(1, 8'h83);
    tick();
    reset_n = 1'b0;
    #1;
    check("midrst_valid", q_valid, 0);
    check("midrst_level", level, 0);
    tick();
    reset_n = 1'b1;
    port_wr(1, 8'h99);
    repeat (2) tick();
    check("postrst_level", level, 0);
    check("postrst_valid", q_valid, 0);

    // Randomized traffic checked by the monitor against the model.
    for (int i = 0; i < 800; i++) begin
      wr      = ($urandom_range(0, 2) != 0);
      addr    = ADDR_W'($urandom_range(0, 7));
      din     = 8'($urandom);
      q_pop   = ($urandom_range(0, 2) == 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    wr = 1'b0; ovf_clr = 1'b0; q_pop = 1'b1;
    repeat (8) tick();
    q_pop = 1'b0;
    check("final_level", level, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
